// File: rtl/mem_bus_ctrl.sv
// Memory/IO bus controller: routes core accesses to external block RAM (bank 0x00)
// or to internal GPIO / cycle counter / TX FIFO registers (bank 0x01), with one-cycle reads.
module mem_bus_ctrl #(
    parameter int RAM_AW      = 15,
    parameter int TX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [23:0]       core_addr,
    input  logic [15:0]       core_wdata,
    input  logic              core_we,
    output logic [15:0]       core_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata,
    input  logic [15:0]       gpio_in,
    output logic [15:0]       gpio_out,
    output logic [15:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              bus_error
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(TX_DEPTH + 1);

    localparam logic [1:0] SEL_RAM      = 2'd0;
    localparam logic [1:0] SEL_IO       = 2'd1;
    localparam logic [1:0] SEL_UNMAPPED = 2'd2;

    localparam logic [15:0] OFF_GPIO_OUT  = 16'h0000;
    localparam logic [15:0] OFF_GPIO_IN   = 16'h0001;
    localparam logic [15:0] OFF_CYCLE_LO  = 16'h0002;
    localparam logic [15:0] OFF_CYCLE_HI  = 16'h0003;
    localparam logic [15:0] OFF_TX_DATA   = 16'h0004;
    localparam logic [15:0] OFF_TX_STATUS = 16'h0005;

    logic [7:0]  bank;
    logic [15:0] offset;
    logic        is_ram;
    logic        is_io;
    logic        is_unmapped;

    logic [1:0]  sel_reg;
    logic [1:0]  sel_next;
    logic [15:0] io_rdata_reg;
    logic [15:0] io_rdata_next;
    logic [15:0] gpio_out_reg;
    logic        bus_err_reg;
    logic [31:0] cycle_reg;
    logic [15:0] hi_snap_reg;
    logic [15:0] sync_reg [SYNC_STAGES];

    logic [15:0]   fifo_mem [TX_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ovf_reg;

    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       tx_write;
    logic       push;
    logic       ovf_set;
    logic       status_rd;
    logic [3:0] count_field;

    assign bank        = core_addr[23:16];
    assign offset      = core_addr[15:0];
    assign is_ram      = (bank == 8'h00);
    assign is_io       = (bank == 8'h01);
    assign is_unmapped = !is_ram && !is_io;

    assign ram_addr  = core_addr[RAM_AW-1:0];
    assign ram_wdata = core_wdata;
    assign ram_we    = core_we && is_ram;

    assign fifo_full   = (count_reg == CW'(TX_DEPTH));
    assign fifo_empty  = (count_reg == '0);
    assign pop         = !fifo_empty && tx_ready;
    assign tx_write    = is_io && core_we && (offset == OFF_TX_DATA);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = tx_write && (!fifo_full || pop);
    assign ovf_set     = tx_write && fifo_full && !pop;
    assign status_rd   = is_io && (offset == OFF_TX_STATUS);
    assign count_field = 4'(count_reg);

    assign tx_data   = fifo_mem[rd_ptr_reg];
    assign tx_valid  = !fifo_empty;
    assign gpio_out  = gpio_out_reg;
    assign bus_error = bus_err_reg;

    always_comb begin
        sel_next = SEL_UNMAPPED;
        if (is_ram) begin
            sel_next = SEL_RAM;
        end else if (is_io) begin
            sel_next = SEL_IO;
        end
    end

    always_comb begin
        io_rdata_next = 16'h0000;
        case (offset)
            OFF_GPIO_OUT:  io_rdata_next = gpio_out_reg;
            OFF_GPIO_IN:   io_rdata_next = sync_reg[SYNC_STAGES-1];
            OFF_CYCLE_LO:  io_rdata_next = cycle_reg[15:0];
            OFF_CYCLE_HI:  io_rdata_next = hi_snap_reg;
            OFF_TX_STATUS: io_rdata_next = {9'b0, ovf_reg, count_field, fifo_empty, fifo_full};
            default:       io_rdata_next = 16'h0000;
        endcase
    end

    always_comb begin
        core_rdata = 16'h0000;
        case (sel_reg)
            SEL_RAM: core_rdata = ram_rdata;
            SEL_IO:  core_rdata = io_rdata_reg;
            default: core_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_reg      <= SEL_RAM;
            io_rdata_reg <= 16'h0000;
        end else begin
            sel_reg      <= sel_next;
            io_rdata_reg <= io_rdata_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_reg <= 16'h0000;
            bus_err_reg  <= 1'b0;
            cycle_reg    <= 32'h0000_0000;
            hi_snap_reg  <= 16'h0000;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (is_io && core_we && (offset == OFF_GPIO_OUT)) begin
                gpio_out_reg <= core_wdata;
            end
            // Latch the upper half at the LO read so a later HI read is coherent.
            if (is_io && (offset == OFF_CYCLE_LO)) begin
                hi_snap_reg <= cycle_reg[31:16];
            end
            if (is_unmapped) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= 16'h0000;
            end
        end else begin
            sync_reg[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (status_rd) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Storage carries no reset; the pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= core_wdata;
        end
    end
endmodule
